mult_mac_acc: RTL and testbench

Signed multiply-accumulate stage built around the generated combinational Booth/prefix multiplier core. It accepts operand pairs over a valid/ready stream, registers operands and the core product in a two-deep pipeline, and accumulates signed products into a saturating accumulator. At the end of each frame, marked by `in_last`, it presents the frame sum on a valid/ready output. It sits directly downstream of the operand source and consumes everything the multiplier core produces.

---
 rtl/mult_mac_acc_pkg.sv | 28 ++
 rtl/mult_mac_acc_booth.sv | 43 ++++
 rtl/mult_mac_acc.sv | 125 ++++++++++++
 tb/tb_mult_mac_acc.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_mac_acc_pkg.sv
// Shared types and helpers for the signed multiply-accumulate stage.
// Holds the pipeline-stage payload, saturation limits and sign extension.
package mult_mac_acc_pkg;

    localparam int unsigned CORE_W = 4;
    localparam int unsigned PROD_W = 2 * CORE_W;
    localparam int unsigned CALC_W = 32;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [PROD_W-1:0] data;
    } stage_t;

    // Largest positive value of an acc_w-bit two's-complement accumulator.
    function automatic logic signed [CALC_W-1:0] acc_max(input int unsigned acc_w);
        return $signed((CALC_W'(1) << (acc_w - 1)) - CALC_W'(1));
    endfunction

    function automatic logic signed [CALC_W-1:0] acc_min(input int unsigned acc_w);
        return ~acc_max(acc_w);
    endfunction

    function automatic logic signed [CALC_W-1:0] sext(input logic [PROD_W-1:0] p);
        return CALC_W'($signed(p));
    endfunction

endpackage

// File: rtl/mult_mac_acc_booth.sv
// Combinational radix-4 Booth signed multiplier core, W x W -> 2W bits.
// Holds no state; the wrapper registers its operands and its product.
module mult_mac_acc_booth #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod_c
);

    localparam int unsigned PW = 2 * W;

    if ((W % 2) != 0) begin : g_even_check
        $error("Booth radix-4 core needs an even operand width");
    end

    logic [W:0]    bx;
    logic [PW-1:0] ae;
    logic [PW-1:0] pp;
    logic [PW-1:0] sum;

    assign bx = {b, 1'b0};
    assign ae = PW'($signed(a));

    // Each overlapping 3-bit window of b selects 0, +-a or +-2a.
    always_comb begin
        sum = '0;
        pp  = '0;
        for (int j = 0; j < int'(W / 2); j++) begin
            case (bx[2*j +: 3])
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae << 1;
                3'b100:         pp = -(ae << 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            sum = sum + (pp << (2 * j));
        end
    end

    assign prod_c = sum;

endmodule

// File: rtl/mult_mac_acc.sv
// Signed multiply-accumulate stage: S1 operands, S2 product, then a saturating
// per-frame accumulator whose frame sum is offered on a valid/ready output.
module mult_mac_acc
    import mult_mac_acc_pkg::*;
#(
    parameter int unsigned WIDTH = CORE_W,
    parameter int unsigned ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam logic signed [CALC_W-1:0] SAT_HI   = acc_max(ACC_W);
    localparam logic signed [CALC_W-1:0] SAT_LO   = acc_min(ACC_W);
    localparam logic        [ACC_W-1:0]  SAT_HI_A = ACC_W'(SAT_HI);
    localparam logic        [ACC_W-1:0]  SAT_LO_A = ACC_W'(SAT_LO);

    if (ACC_W < 2 * WIDTH) begin : g_acc_w_check
        $error("ACC_W must be at least 2*WIDTH");
    end
    if (WIDTH != CORE_W || ACC_W >= CALC_W) begin : g_width_check
        $error("WIDTH must match the core and ACC_W must stay below CALC_W");
    end

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, state_nxt;
    stage_t            s1, s1_nxt, s2, s2_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt, out_acc_nxt;
    logic              ovf_sticky, sticky_nxt, out_ovf_nxt;
    logic [PROD_W-1:0] prod_c;
    logic signed [CALC_W-1:0] sum_w;
    logic [ACC_W-1:0]  sum;
    logic              ovf_now;
    logic              stall;

    mult_mac_acc_booth #(.W(WIDTH)) u_core (
        .a      (s1.data[PROD_W-1:WIDTH]),
        .b      (s1.data[WIDTH-1:0]),
        .prod_c (prod_c)
    );

    assign out_valid = (state == HOLD);
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // Wide add cannot wrap, so clamping is a plain signed compare.
    always_comb begin
        sum_w   = CALC_W'($signed(acc)) + sext(s2.data);
        ovf_now = 1'b0;
        if (sum_w > SAT_HI) begin
            sum     = SAT_HI_A;
            ovf_now = 1'b1;
        end else if (sum_w < SAT_LO) begin
            sum     = SAT_LO_A;
            ovf_now = 1'b1;
        end else begin
            sum = ACC_W'(sum_w);
        end
    end

    always_comb begin
        state_nxt   = state;
        s1_nxt      = s1;
        s2_nxt      = s2;
        acc_nxt     = acc;
        sticky_nxt  = ovf_sticky;
        out_acc_nxt = out_acc;
        out_ovf_nxt = out_ovf;
        if (!stall) begin
            s1_nxt.valid = in_valid;
            s1_nxt.last  = in_last;
            s1_nxt.data  = {in_a, in_b};
            s2_nxt.valid = s1.valid;
            s2_nxt.last  = s1.last;
            s2_nxt.data  = prod_c;
            if (state == HOLD) begin
                state_nxt = ACCUM;
            end
            // A closing product reloads the output even while one is being consumed.
            if (s2.valid) begin
                if (s2.last) begin
                    out_acc_nxt = sum;
                    out_ovf_nxt = ovf_sticky | ovf_now;
                    state_nxt   = HOLD;
                    acc_nxt     = '0;
                    sticky_nxt  = 1'b0;
                end else begin
                    acc_nxt    = sum;
                    sticky_nxt = ovf_sticky | ovf_now;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            s1         <= '0;
            s2         <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            out_acc    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            state      <= state_nxt;
            s1         <= s1_nxt;
            s2         <= s2_nxt;
            acc        <= acc_nxt;
            ovf_sticky <= sticky_nxt;
            out_acc    <= out_acc_nxt;
            out_ovf    <= out_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mult_mac_acc.sv
// Self-checking bench for mult_mac_acc: two instances (ACC_W 10 and 8) share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_mult_mac_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, out_ready;
    logic [3:0] in_a, in_b;
    logic       ir10, ov10, of10, ir8, ov8, of8;
    logic [9:0] oa10;
    logic [7:0] oa8;

    always #5 clk = ~clk;

    mult_mac_acc #(.WIDTH(4), .ACC_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir10),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov10),
        .out_ready(out_ready), .out_acc(oa10), .out_ovf(of10)
    );

    mult_mac_acc #(.WIDTH(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov8),
        .out_ready(out_ready), .out_acc(oa8), .out_ovf(of8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Frame model: results are tagged with the count of non-stalled edges at
    // acceptance and appear two non-stalled edges later.
    typedef struct {
        int tag;
        int v[2];
        bit o[2];
    } res_t;

    int   accw[2] = '{10, 8};
    res_t pend[$];
    int   run[2];
    bit   rov[2];
    bit   hold;
    int   cur_v[2];
    bit   cur_o[2];
    int   adv;

    always @(posedge clk or negedge rst_n) begin : model
        res_t r;
        int   p, s, mx, mn;
        bit   o;
        if (!rst_n) begin
            pend.delete();
            hold = 1'b0;
            adv  = 0;
            for (int k = 0; k < 2; k++) begin
                run[k] = 0;
                rov[k] = 1'b0;
            end
        end else if (!(hold && !out_ready)) begin
            if (hold) hold = 1'b0;
            if (pend.size() != 0 && pend[0].tag + 2 == adv) begin
                r     = pend.pop_front();
                hold  = 1'b1;
                cur_v = r.v;
                cur_o = r.o;
            end
            if (in_valid) begin
                p = int'($signed(in_a)) * int'($signed(in_b));
                for (int k = 0; k < 2; k++) begin
                    mx = (1 << (accw[k] - 1)) - 1;
                    mn = -mx - 1;
                    s  = run[k] + p;
                    o  = 1'b0;
                    if (s > mx) begin s = mx; o = 1'b1; end
                    if (s < mn) begin s = mn; o = 1'b1; end
                    if (in_last) begin
                        r.v[k] = s;
                        r.o[k] = rov[k] | o;
                        run[k] = 0;
                        rov[k] = 1'b0;
                    end else begin
                        run[k] = s;
                        rov[k] = rov[k] | o;
                    end
                end
                if (in_last) begin
                    r.tag = adv;
                    pend.push_back(r);
                end
            end
            adv++;
        end
    end

    int got10[$];
    int got8[$];
    bit gov10[$];
    bit gov8[$];
    int stall_seen = 0;

    // Per-cycle compare, sampled mid-low-phase once inputs for the next edge are settled.
    always begin
        @(negedge clk);
        #3;
        check("valid10", ov10, hold);
        check("valid8", ov8, hold);
        check("ready10", ir10, !(hold && !out_ready));
        check("ready8", ir8, !(hold && !out_ready));
        if (hold) begin
            check("acc10", int'($signed(oa10)), cur_v[0]);
            check("ovf10", of10, cur_o[0]);
            check("acc8", int'($signed(oa8)), cur_v[1]);
            check("ovf8", of8, cur_o[1]);
        end
        if (!ir10) stall_seen++;
        if (ov10 && out_ready && rst_n) begin
            got10.push_back(int'($signed(oa10)));
            gov10.push_back(of10);
            got8.push_back(int'($signed(oa8)));
            gov8.push_back(of8);
        end
    end

    int rdy_mode = 0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Called at negedge+1; returns at negedge+1 right after the accepting edge.
    task automatic send(input int a, input int b, input bit last);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_last  = last;
        n        = 0;
        do begin
            #2;
            ok = ir10;
            @(negedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        rdy_mode = 0;
        n = 0;
        while ((pend.size() != 0 || hold) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, st0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", ov10, 0);
        check("rst_ready", ir10, 1);
        check("rst_acc", int'($signed(oa10)), 0);
        check("rst_ovf", of10, 0);
        check("rst_acc8", int'($signed(oa8)), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Single pair, held output while the consumer is not ready.
        rdy_mode = 2;
        @(negedge clk);
        #1;
        send(3, -2, 1'b1);
        @(negedge clk);
        check("lat_early", ov10, 0);
        @(negedge clk);
        check("lat_valid", ov10, 1);
        check("lat_acc", int'($signed(oa10)), -6);
        check("lat_ovf", of10, 0);
        repeat (3) @(negedge clk);
        check("held_acc", int'($signed(oa10)), -6);
        check("held_valid", ov10, 1);
        #1;
        drain();

        // Three-element frame, then a fresh frame starting from zero.
        send(1, 1, 1'b0);
        send(2, 3, 1'b0);
        send(-4, 5, 1'b1);
        drain();
        check("frame3_10", got10[$], -13);
        check("frame3_8", got8[$], -13);
        send(2, 2, 1'b1);
        drain();
        check("restart", got10[$], 4);

        // Saturation in the narrow accumulator; most-negative square alone is fine.
        send(-8, -8, 1'b0);
        send(-8, -8, 1'b1);
        drain();
        check("sat8_acc", got8[$], 127);
        check("sat8_ovf", gov8[$], 1);
        check("nosat10_acc", got10[$], 128);
        check("nosat10_ovf", gov10[$], 0);
        send(-8, -8, 1'b1);
        drain();
        check("minsq8_acc", got8[$], 64);
        check("minsq8_ovf", gov8[$], 0);

        // Clamped sum can come back inside range; overflow stays flagged.
        for (int i = 0; i < 9; i++) send(-8, -8, 1'b0);
        send(7, -8, 1'b1);
        drain();
        check("clamp_back10", got10[$], 455);
        check("clamp_ovf10", gov10[$], 1);
        check("clamp_back8", got8[$], 71);
        check("clamp_ovf8", gov8[$], 1);

        // Back-to-back single-pair frames into a stalled consumer.
        c0  = got10.size();
        st0 = stall_seen;
        rdy_mode = 2;
        @(negedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(i - 2, 3, 1'b1);
            end
            begin
                repeat (4) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        check("b2b_count", got10.size(), c0 + 6);
        for (int i = 0; i < 6; i++) check("b2b_order", got10[c0 + i], (i - 2) * 3);
        check("b2b_stalled", int'(stall_seen > st0), 1);

        // Every operand pair as its own frame, with a jittery consumer.
        c0 = got10.size();
        rdy_mode = 1;
        for (int a = -8; a < 8; a++)
            for (int b = -8; b < 8; b++) send(a, b, 1'b1);
        drain();
        check("exh_count", got10.size(), c0 + 256);
        check("exh_first", got10[c0], 64);
        check("exh_last", got10[c0 + 255], 49);

        // Random frames, biased toward the most-negative operand to hit saturation.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                int a, b;
                a = ($urandom_range(0, 2) == 0) ? -8 : int'($signed(4'($urandom_range(0, 15))));
                b = ($urandom_range(0, 2) == 0) ? -8 : int'($signed(4'($urandom_range(0, 15))));
                send(a, b, i == len - 1);
                if ($urandom_range(0, 5) == 0) begin
                    @(negedge clk);
                    #1;
                end
            end
        end
        drain();

        // Reset in the middle of a frame discards the partial sum.
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", ov10, 0);
        check("midrst_ready", ir10, 1);
        check("midrst_acc", int'($signed(oa10)), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        c0 = got10.size();
        send(2, 2, 1'b1);
        drain();
        check("postrst_count", got10.size(), c0 + 1);
        check("postrst_acc", got10[$], 4);
        check("postrst_ovf", gov10[$], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
